// File: rtl/text_overlay_ctrl_pkg.sv
// Shared constants, commit-state encoding and glyph helper for the text overlay.
package text_overlay_ctrl_pkg;

    localparam int         FONT_W     = 8;
    localparam int         FONT_H     = 8;
    localparam int         MAX_COLS   = 32;
    localparam logic [7:0] SPACE_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COPY
    } commit_state_t;

    // Font rows are MSB-leftmost, so column 0 maps to bit FONT_W-1.
    function automatic logic glyph_bit(input logic [FONT_W-1:0] row_bits, input logic [2:0] col);
        return row_bits[3'(FONT_W - 1) - col];
    endfunction

endpackage

// File: rtl/text_line_buffer.sv
// Shadow/display character buffers with a host write port and a vsync-gated commit engine.
module text_line_buffer
    import text_overlay_ctrl_pkg::*;
#(
    parameter int COLS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_char,
    input  logic       vsync_in,
    input  logic [4:0] rd_col,
    output logic [7:0] rd_char,
    output logic       wr_ready
);

    localparam logic [5:0] NCOLS    = 6'(COLS);
    localparam logic [4:0] LAST_IDX = 5'(COLS - 1);

    logic [7:0]    shadow  [MAX_COLS];
    logic [7:0]    display [MAX_COLS];
    commit_state_t state;
    logic [4:0]    idx;
    logic          wr_hit;

    // Out-of-range slots complete the handshake but neither store nor arm a commit.
    assign wr_hit  = wr_en && wr_ready && ({1'b0, wr_addr} < NCOLS);
    assign rd_char = display[rd_col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            wr_ready <= 1'b1;
            for (int i = 0; i < MAX_COLS; i++) begin
                shadow[i]  <= SPACE_CHAR;
                display[i] <= SPACE_CHAR;
            end
        end else begin
            if (wr_hit) begin
                shadow[wr_addr] <= wr_char;
            end
            unique case (state)
                IDLE: begin
                    if (wr_hit) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (vsync_in) begin
                        state    <= COPY;
                        idx      <= '0;
                        wr_ready <= 1'b0;
                    end
                end
                COPY: begin
                    display[idx] <= shadow[idx];
                    if (idx == LAST_IDX) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/text_overlay_ctrl.sv
// Single-line text overlay: region decode, font ROM sequencing and 2-cycle pixel/sync pipeline.
module text_overlay_ctrl
    import text_overlay_ctrl_pkg::*;
#(
    parameter int COLS     = 16,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] pix_x,
    input  logic [CW-1:0] pix_y,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          wr_en,
    input  logic [4:0]    wr_addr,
    input  logic [7:0]    wr_char,
    output logic          wr_ready,
    output logic [7:0]    font_char,
    output logic [2:0]    font_row,
    input  logic [7:0]    font_pixels,
    output logic          pix_on,
    output logic          de_out,
    output logic          hsync_out,
    output logic          vsync_out
);

    localparam logic signed [CW:0] ORG_X  = (CW+1)'(ORIGIN_X);
    localparam logic signed [CW:0] ORG_Y  = (CW+1)'(ORIGIN_Y);
    localparam logic signed [CW:0] X_SPAN = (CW+1)'(FONT_W * COLS);
    localparam logic signed [CW:0] Y_SPAN = (CW+1)'(FONT_H);

    logic signed [CW:0] off_x_p0;
    logic signed [CW:0] off_y_p0;
    logic               vld_p0;
    logic [7:0]         rd_char_p0;

    logic [2:0]         bit_p1;
    logic               vld_p1;
    logic               de_p1;
    logic               hsync_p1;
    logic               vsync_p1;

    // Stage 0: signed offsets one bit wider than the coordinates, so nothing wraps.
    assign off_x_p0 = $signed({1'b0, pix_x}) - ORG_X;
    assign off_y_p0 = $signed({1'b0, pix_y}) - ORG_Y;
    assign vld_p0   = de_in
                   && !off_x_p0[CW] && (off_x_p0 < X_SPAN)
                   && !off_y_p0[CW] && (off_y_p0 < Y_SPAN);

    text_line_buffer #(
        .COLS (COLS)
    ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_char  (wr_char),
        .vsync_in (vsync_in),
        .rd_col   (off_x_p0[7:3]),
        .rd_char  (rd_char_p0),
        .wr_ready (wr_ready)
    );

    // Stage 1: font ROM address plus the bit select and controls that travel with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            font_char <= SPACE_CHAR;
            font_row  <= '0;
            bit_p1    <= '0;
            vld_p1    <= 1'b0;
            de_p1     <= 1'b0;
            hsync_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
        end else begin
            font_char <= vld_p0 ? rd_char_p0 : SPACE_CHAR;
            font_row  <= off_y_p0[2:0];
            bit_p1    <= off_x_p0[2:0];
            vld_p1    <= vld_p0;
            de_p1     <= de_in;
            hsync_p1  <= hsync_in;
            vsync_p1  <= vsync_in;
        end
    end

    // Stage 2: glyph bit select on the ROM's combinational row data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_on    <= 1'b0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            pix_on    <= vld_p1 & glyph_bit(font_pixels, bit_p1);
            de_out    <= de_p1;
            hsync_out <= hsync_p1;
            vsync_out <= vsync_p1;
        end
    end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Randomised and directed bench for text_overlay_ctrl against a frame-level reference model.
module tb_text_overlay_ctrl;

    localparam int COLS  = 16;
    localparam int OX    = 40;
    localparam int OY    = 100;
    localparam int CW    = 10;
    localparam int X_END = OX + 8 * COLS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] pix_x = '0;
    logic [CW-1:0] pix_y = '0;
    logic          de_in = 1'b0;
    logic          hsync_in = 1'b0;
    logic          vsync_in = 1'b0;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_addr = '0;
    logic [7:0]    wr_char = '0;
    logic          wr_ready;
    logic [7:0]    font_char;
    logic [2:0]    font_row;
    logic [7:0]    font_pixels;
    logic          pix_on;
    logic          de_out;
    logic          hsync_out;
    logic          vsync_out;

    always #5 clk = ~clk;

    text_overlay_ctrl #(
        .COLS(COLS), .ORIGIN_X(OX), .ORIGIN_Y(OY), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .wr_ready(wr_ready), .font_char(font_char), .font_row(font_row),
        .font_pixels(font_pixels), .pix_on(pix_on), .de_out(de_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    // Bench-owned font ROM: space is blank, other glyphs are an arbitrary pattern.
    function automatic logic [7:0] rom(input logic [7:0] c, input logic [2:0] r);
        if (c == 8'h20) return 8'h00;
        return (c * 8'd29) ^ {r, r, r[1:0]} ^ 8'h5A;
    endfunction

    always_comb font_pixels = rom(font_char, font_row);

    typedef struct packed {
        logic [7:0] fc;
        logic [2:0] row;
        logic       on;
        logic       de;
        logic       hs;
        logic       vs;
    } exp_t;

    localparam exp_t RST_EXP = '{fc: 8'h20, row: 3'd0, on: 1'b0, de: 1'b0, hs: 1'b0, vs: 1'b0};

    logic [7:0] m_shadow [32];
    logic [7:0] m_disp   [32];
    bit         m_pending;
    int         m_copy_left;
    exp_t       exp1, exp2;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_shadow[i] = 8'h20;
            m_disp[i]   = 8'h20;
        end
        m_pending   = 1'b0;
        m_copy_left = 0;
        exp1        = RST_EXP;
        exp2        = RST_EXP;
    endtask

    function automatic exp_t model_pix();
        exp_t       e;
        int         dx, dy;
        bit         inr;
        logic [7:0] g;
        dx   = int'(pix_x) - OX;
        dy   = int'(pix_y) - OY;
        inr  = de_in && dx >= 0 && dx < 8 * COLS && dy >= 0 && dy < 8;
        e.fc = 8'h20;
        if (inr) e.fc = m_disp[dx / 8];
        e.row = 3'(dy & 7);
        g     = rom(e.fc, e.row);
        e.on  = inr && g[7 - (dx & 7)];
        e.de  = de_in;
        e.hs  = hsync_in;
        e.vs  = vsync_in;
        return e;
    endfunction

    // One clock: predict this cycle's pixel, apply host/commit rules, advance the 2-deep expectation.
    task automatic step();
        exp_t cur;
        bit   hit;
        cur = model_pix();
        hit = wr_en && (m_copy_left == 0) && (wr_addr < 5'(COLS));
        if (m_copy_left > 0) begin
            m_copy_left--;
            if (m_copy_left == 0) m_disp = m_shadow;
        end else begin
            if (hit) m_shadow[wr_addr] = wr_char;
            if (m_pending && vsync_in) begin
                m_copy_left = COLS;
                m_pending   = 1'b0;
            end else if (hit) begin
                m_pending = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        exp2 = exp1;
        exp1 = cur;
    endtask

    task automatic commit();
        de_in    = 1'b0;
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        for (int i = 0; i < COLS + 3; i++) step();
    endtask

    task automatic scan_row(input int y, input int xa, input int xb);
        pix_y = CW'(y);
        de_in = 1'b1;
        for (int x = xa; x <= xb + 2; x++) begin
            if (x <= xb) pix_x = CW'(x);
            else de_in = 1'b0;
            step();
            n_cmp++;
            if (font_char !== exp1.fc || font_row !== exp1.row) begin
                n_bad++;
                $display("FAIL scan_stage1 x=%0d y=%0d: font_char=%h row=%0d, want %h row=%0d",
                         x, y, font_char, font_row, exp1.fc, exp1.row);
            end
            n_cmp++;
            if (pix_on !== exp2.on || de_out !== exp2.de) begin
                n_bad++;
                $display("FAIL scan_stage2 x=%0d y=%0d: pix_on=%b de_out=%b, want %b %b",
                         x, y, pix_on, de_out, exp2.on, exp2.de);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({font_char, font_row, pix_on, de_out, hsync_out, vsync_out} !== {8'h20, 3'd0, 4'b0000}) begin
            n_bad++;
            $display("FAIL reset_outputs: char=%h row=%0d on=%b de=%b hs=%b vs=%b, want 20 0 0 0 0 0",
                     font_char, font_row, pix_on, de_out, hsync_out, vsync_out);
        end
        rst_n = 1'b1;
        model_reset();
        step();
        n_cmp++;
        if (wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
        scan_row(OY, OX - 2, X_END + 1);
    endtask

    task automatic test_commit();
        logic [7:0] prog [4];
        int         low;
        prog = '{"P", "R", "O", "G"};
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i);
            wr_char = prog[i];
            n_cmp++;
            if (wr_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL commit_wr_ready slot %0d: got %b want 1", i, wr_ready);
            end
            step();
        end
        wr_en = 1'b0;
        scan_row(OY, OX, OX + 31);
        de_in    = 1'b0;
        vsync_in = 1'b1;
        step();
        low = 0;
        for (int i = 0; i < COLS + 6; i++) begin
            if (i == 3) vsync_in = 1'b0;
            if (wr_ready === 1'b0) low++;
            step();
        end
        n_cmp++;
        if (low != COLS) begin
            n_bad++;
            $display("FAIL copy_length: wr_ready low %0d cycles, want %0d", low, COLS);
        end
        scan_row(OY, OX, OX + 31);
    endtask

    task automatic test_align();
        logic [7:0] c;
        de_in    = 1'b1;
        pix_y    = CW'(OY);
        pix_x    = CW'(5);
        hsync_in = 1'b1;
        step();
        hsync_in = 1'b0;
        pix_x    = CW'(6);
        n_cmp++;
        if (hsync_out !== 1'b0) begin n_bad++; $display("FAIL hsync_lag1: got %b want 0", hsync_out); end
        step();
        n_cmp++;
        if (hsync_out !== 1'b1) begin n_bad++; $display("FAIL hsync_lag2: got %b want 1", hsync_out); end
        step();
        n_cmp++;
        if (hsync_out !== 1'b0) begin n_bad++; $display("FAIL hsync_lag3: got %b want 0", hsync_out); end
        c = 8'h21;
        for (int k = 33; k < 127; k++) begin
            if (rom(8'(k), 3'd0) & 8'h01) begin
                c = 8'(k);
                break;
            end
        end
        wr_en   = 1'b1;
        wr_addr = 5'(COLS - 1);
        wr_char = c;
        step();
        wr_en = 1'b0;
        commit();
        de_in = 1'b1;
        pix_y = CW'(OY);
        pix_x = CW'(X_END - 1);
        step();
        pix_x = CW'(X_END);
        step();
        n_cmp++;
        if (font_char !== 8'h20) begin n_bad++; $display("FAIL edge_char_beyond: got %h want 20", font_char); end
        n_cmp++;
        if (pix_on !== 1'b1) begin n_bad++; $display("FAIL edge_last_pixel: got %b want 1", pix_on); end
        de_in = 1'b0;
        step();
        n_cmp++;
        if (pix_on !== 1'b0) begin n_bad++; $display("FAIL edge_beyond_pixel: got %b want 0", pix_on); end
    endtask

    task automatic test_copy_write();
        de_in   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_char = "A";
        step();
        wr_addr  = 5'd2;
        wr_char  = "Q";
        vsync_in = 1'b1;
        step();
        wr_char = "X";
        for (int i = 0; i < COLS; i++) begin
            n_cmp++;
            if (wr_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL copy_wr_ready cycle %0d: got %b want 0", i, wr_ready);
            end
            step();
        end
        wr_en    = 1'b0;
        vsync_in = 1'b0;
        step();
        scan_row(OY + 3, OX + 16, OX + 23);
        de_in = 1'b1;
        pix_y = CW'(OY);
        pix_x = CW'(OX + 17);
        step();
        n_cmp++;
        if (font_char !== "Q") begin n_bad++; $display("FAIL sample_cycle_write: got %h want %h", font_char, 8'("Q")); end
        de_in   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_char = "B";
        step();
        wr_en = 1'b0;
        commit();
        de_in = 1'b1;
        pix_x = CW'(OX + 16);
        step();
        n_cmp++;
        if (font_char !== "Q") begin n_bad++; $display("FAIL copy_write_ignored: got %h want %h", font_char, 8'("Q")); end
        pix_x = CW'(OX + 56);
        step();
        n_cmp++;
        if (font_char !== "B") begin n_bad++; $display("FAIL second_commit: got %h want %h", font_char, 8'("B")); end
        de_in = 1'b0;
        step();
    endtask

    task automatic test_bad_addr();
        de_in   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd20;
        wr_char = "Z";
        n_cmp++;
        if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL bad_addr_ready: got %b want 1", wr_ready); end
        step();
        wr_en    = 1'b0;
        vsync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (wr_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL bad_addr_no_commit cycle %0d: wr_ready=%b want 1", i, wr_ready);
            end
        end
        vsync_in = 1'b0;
        scan_row(OY + 7, OX - 1, X_END);
    endtask

    task automatic test_reset_midcopy();
        de_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = 5'(i + 8);
            wr_char = 8'("a" + i);
            step();
        end
        wr_en    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        step();
        repeat (7) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({font_char, font_row, pix_on, de_out, hsync_out, vsync_out} !== {8'h20, 3'd0, 4'b0000}) begin
            n_bad++;
            $display("FAIL midcopy_reset_outputs: char=%h row=%0d on=%b de=%b hs=%b vs=%b, want 20 0 0 0 0 0",
                     font_char, font_row, pix_on, de_out, hsync_out, vsync_out);
        end
        n_cmp++;
        if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL midcopy_reset_ready: got %b want 1", wr_ready); end
        @(posedge clk);
        #1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        scan_row(OY, OX, X_END - 1);
        scan_row(OY + 5, OX, X_END - 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = 5'($urandom_range(0, 23));
            wr_char  = 8'($urandom_range(33, 126));
            vsync_in = ($urandom_range(0, 24) == 0);
            hsync_in = 1'($urandom_range(0, 1));
            de_in    = (m_copy_left == 0) && ($urandom_range(0, 3) != 0);
            pix_x    = CW'($urandom_range(OX - 10, X_END + 10));
            pix_y    = CW'($urandom_range(OY - 3, OY + 10));
            n_cmp++;
            if (wr_ready !== (m_copy_left == 0)) begin
                n_bad++;
                $display("FAIL rand_wr_ready i=%0d: got %b want %b", i, wr_ready, m_copy_left == 0);
            end
            step();
            n_cmp++;
            if (font_char !== exp1.fc || font_row !== exp1.row) begin
                n_bad++;
                $display("FAIL rand_stage1 i=%0d: char=%h row=%0d, want %h %0d",
                         i, font_char, font_row, exp1.fc, exp1.row);
            end
            n_cmp++;
            if ({pix_on, de_out, hsync_out, vsync_out} !== {exp2.on, exp2.de, exp2.hs, exp2.vs}) begin
                n_bad++;
                $display("FAIL rand_stage2 i=%0d: on/de/hs/vs=%b%b%b%b, want %b%b%b%b", i,
                         pix_on, de_out, hsync_out, vsync_out, exp2.on, exp2.de, exp2.hs, exp2.vs);
            end
        end
        de_in    = 1'b0;
        wr_en    = 1'b0;
        vsync_in = 1'b0;
        hsync_in = 1'b0;
        repeat (COLS + 2) step();
        scan_row(OY + 2, OX, X_END - 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_commit();
        test_align();
        test_copy_write();
        test_bad_addr();
        test_reset_midcopy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
